// File: rtl/ovi_issue_responder.sv
// Vector-side end of the OVI issue/completion interface: queues issue beats in order
// and returns one completion per instruction after a vl/sew-dependent latency.
//
//   state | meaning
//   IDLE  | nothing executing, waiting for a queued instruction
//   EXEC  | instruction popped, latency counter running down
//   DONE  | completion beat presented for exactly one cycle
module ovi_issue_responder #(
    parameter int INSTR_W    = 32,
    parameter int VL_W       = 14,
    parameter int SEW_W      = 3,
    parameter int DEPTH      = 4,
    parameter int BASE_LAT   = 2,
    parameter int LANE_BYTES = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     ISSUE_VALID,
    input  logic [INSTR_W-1:0]       ISSUE_INSTR,
    input  logic [VL_W-1:0]          ISSUE_VL,
    input  logic [SEW_W-1:0]         ISSUE_SEW,
    output logic                     ISSUE_HALT,
    output logic                     COMPLETED_VALID,
    output logic [4:0]               COMPLETED_DEST_REG,
    output logic                     COMPLETED_ILLEGAL,
    output logic [4:0]               COMPLETED_FFLAGS,
    output logic                     OVERFLOW,
    output logic [$clog2(DEPTH):0]   OCCUPANCY
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = VL_W + 1;
    localparam int LB_LOG = $clog2(LANE_BYTES);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state, next_state;
    logic               pop, done_evt, push, full, empty;
    logic [PTR_W:0]     wr_ptr, rd_ptr, count, count_next;
    logic [PTR_W-1:0]   rd_idx;

    logic [4:0]         q_dest [DEPTH];
    logic               q_ill  [DEPTH];
    logic [CNT_W-1:0]   q_lat  [DEPTH];

    logic [CNT_W-1:0]   cnt;
    logic [4:0]         cur_dest;
    logic               cur_ill;
    logic [4:0]         comp_dest;
    logic               comp_ill;
    logic               overflow_q, halt_q;

    logic               sew_illegal;
    logic [CNT_W-1:0]   vl_ext, beats, lat_new;
    logic               unused_instr_bits;

    assign unused_instr_bits = ^{ISSUE_INSTR[INSTR_W-1:12], ISSUE_INSTR[6:0]};

    // Element-per-cycle is a power of two, so the ceiling divide is round-up-and-shift.
    assign sew_illegal = ISSUE_SEW > SEW_W'(3);
    assign vl_ext      = CNT_W'(ISSUE_VL);

    always_comb begin
        beats = '0;
        case (ISSUE_SEW[1:0])
            2'd0:    beats = (vl_ext + CNT_W'(LANE_BYTES - 1))     >> LB_LOG;
            2'd1:    beats = (vl_ext + CNT_W'(LANE_BYTES / 2 - 1)) >> (LB_LOG - 1);
            2'd2:    beats = (vl_ext + CNT_W'(LANE_BYTES / 4 - 1)) >> (LB_LOG - 2);
            default: beats = (vl_ext + CNT_W'(LANE_BYTES / 8 - 1)) >> (LB_LOG - 3);
        endcase
        lat_new = sew_illegal ? CNT_W'(BASE_LAT) : CNT_W'(BASE_LAT) + beats;
    end

    assign count      = wr_ptr - rd_ptr;
    assign full       = count == (PTR_W+1)'(DEPTH);
    assign empty      = count == '0;
    assign push       = ISSUE_VALID && !full;
    assign rd_idx     = rd_ptr[PTR_W-1:0];
    assign count_next = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        done_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (cnt == CNT_W'(1)) begin
                    done_evt   = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = EXEC;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Queue storage needs no reset; pointers alone define validity.
    always_ff @(posedge CLK) begin
        if (push) begin
            q_dest[wr_ptr[PTR_W-1:0]] <= ISSUE_INSTR[11:7];
            q_ill[wr_ptr[PTR_W-1:0]]  <= sew_illegal;
            q_lat[wr_ptr[PTR_W-1:0]]  <= lat_new;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            cur_dest   <= '0;
            cur_ill    <= 1'b0;
            comp_dest  <= '0;
            comp_ill   <= 1'b0;
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + (PTR_W+1)'(1);
                cnt      <= q_lat[rd_idx];
                cur_dest <= q_dest[rd_idx];
                cur_ill  <= q_ill[rd_idx];
            end else if (state == EXEC) begin
                cnt <= cnt - CNT_W'(1);
            end
            comp_dest <= done_evt ? cur_dest : 5'd0;
            comp_ill  <= done_evt ? cur_ill  : 1'b0;
            if (ISSUE_VALID && full) overflow_q <= 1'b1;
            // One spare entry absorbs the beat the issuer may send before seeing HALT.
            halt_q <= count_next >= (PTR_W+1)'(DEPTH - 1);
        end
    end

    assign ISSUE_HALT         = halt_q;
    assign COMPLETED_VALID    = state == DONE;
    assign COMPLETED_DEST_REG = comp_dest;
    assign COMPLETED_ILLEGAL  = comp_ill;
    assign COMPLETED_FFLAGS   = 5'd0;
    assign OVERFLOW           = overflow_q;
    assign OCCUPANCY          = count;

endmodule

// File: tb/tb_ovi_issue_responder.sv
// Directed bench for ovi_issue_responder: latency per vl/sew, fill/overflow,
// back-to-back spacing and reset while executing.
module tb_ovi_issue_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic [13:0] issue_vl;
    logic [2:0]  issue_sew;
    logic        issue_halt;
    logic        completed_valid;
    logic [4:0]  completed_dest_reg;
    logic        completed_illegal;
    logic [4:0]  completed_fflags;
    logic        overflow;
    logic [2:0]  occupancy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ovi_issue_responder dut (
        .CLK                (clk),
        .RST_N              (rst_n),
        .ISSUE_VALID        (issue_valid),
        .ISSUE_INSTR        (issue_instr),
        .ISSUE_VL           (issue_vl),
        .ISSUE_SEW          (issue_sew),
        .ISSUE_HALT         (issue_halt),
        .COMPLETED_VALID    (completed_valid),
        .COMPLETED_DEST_REG (completed_dest_reg),
        .COMPLETED_ILLEGAL  (completed_illegal),
        .COMPLETED_FFLAGS   (completed_fflags),
        .OVERFLOW           (overflow),
        .OCCUPANCY          (occupancy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] d);
        return {20'hA5C3F, d, 7'h57};
    endfunction

    task automatic set_beat(input logic [4:0] d, input int vl, input int sew);
        issue_valid = 1'b1;
        issue_instr = mk_instr(d);
        issue_vl    = 14'(vl);
        issue_sew   = 3'(sew);
    endtask

    // Issue one beat into an idle system; pulse expected in the cycle after E(1+L).
    task automatic run_one(input string tag, input logic [4:0] d, input int vl,
                           input int sew, input int lat, input logic ill);
        int k;
        bit seen;
        @(negedge clk);
        set_beat(d, vl, sew);
        @(negedge clk);
        issue_valid = 1'b0;
        k = 0;
        seen = 0;
        while (!seen && k < lat + 20) begin
            @(negedge clk);
            k++;
            if (completed_valid) seen = 1;
        end
        check_val({tag, "_lat"}, seen ? k : 0, 1 + lat);
        check_val({tag, "_dest"}, completed_dest_reg, d);
        check_val({tag, "_ill"}, completed_illegal, ill);
        check_val({tag, "_fflags"}, completed_fflags, 0);
        @(negedge clk);
        check_val({tag, "_pulse_end"}, completed_valid, 0);
        check_val({tag, "_dest_clr"}, completed_dest_reg, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_occ  [5] = '{1, 2, 3, 4, 4};
        int exp_halt [5] = '{0, 0, 1, 1, 1};
        int exp_ovf  [5] = '{0, 0, 0, 0, 1};
        int exp_dest [5] = '{30, 1, 2, 3, 4};
        int got_dest [5];
        int t_pulse  [3];
        int n;
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_instr = '0;
        issue_vl    = '0;
        issue_sew   = '0;
        #12;
        check_val("rst_valid", completed_valid, 0);
        check_val("rst_halt", issue_halt, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_occ", occupancy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_one("sew2_vl8",   5'd21, 8,     2, 4,    1'b0);
        run_one("sew3_vl8",   5'd3,  8,     3, 6,    1'b0);
        run_one("sew0_vl17",  5'd17, 17,    0, 4,    1'b0);
        run_one("vl0",        5'd9,  0,     1, 2,    1'b0);
        run_one("sew5_ill",   5'd31, 8,     5, 2,    1'b1);
        run_one("sew1_vl8",   5'd14, 8,     1, 3,    1'b0);
        run_one("sew0_vlmax", 5'd1,  16383, 0, 1026, 1'b0);

        // Fill: long instruction executing, then five beats with HALT ignored.
        @(negedge clk);
        set_beat(5'd30, 200, 0);
        @(negedge clk);
        issue_valid = 1'b0;
        @(negedge clk);
        check_val("fill_occ_start", occupancy, 0);
        for (int i = 0; i < 5; i++) begin
            set_beat(5'(i + 1), 1, 2);
            @(negedge clk);
            check_val($sformatf("fill_occ%0d", i), occupancy, exp_occ[i]);
            check_val($sformatf("fill_halt%0d", i), issue_halt, exp_halt[i]);
            check_val($sformatf("fill_ovf%0d", i), overflow, exp_ovf[i]);
        end
        issue_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (completed_valid) begin
                if (n < 5) got_dest[n] = completed_dest_reg;
                n++;
            end
        end
        check_val("fill_count", n, 5);
        for (int i = 0; i < 5; i++)
            check_val($sformatf("fill_order%0d", i), (i < n) ? got_dest[i] : 99, exp_dest[i]);
        check_val("fill_drained_occ", occupancy, 0);
        check_val("fill_drained_halt", issue_halt, 0);
        check_val("fill_ovf_sticky", overflow, 1);

        // Back-to-back: beats pushed at iterations 0..2, L=3 each.
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 3) set_beat(5'(7 + c), 4, 2);
            else       issue_valid = 1'b0;
            @(negedge clk);
            if (completed_valid) begin
                if (n < 3) begin
                    t_pulse[n] = c;
                    check_val($sformatf("b2b_dest%0d", n), completed_dest_reg, 7 + n);
                end
                n++;
            end
        end
        check_val("b2b_count", n, 3);
        check_val("b2b_t0", (n > 0) ? t_pulse[0] : 0, 4);
        check_val("b2b_t1", (n > 1) ? t_pulse[1] : 0, 8);
        check_val("b2b_t2", (n > 2) ? t_pulse[2] : 0, 12);

        // Reset while executing an L=9 instruction.
        @(negedge clk);
        set_beat(5'd11, 100, 0);
        @(negedge clk);
        set_beat(5'd12, 4, 2);
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_val("pre_rst_occ", occupancy, 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", completed_valid, 0);
        check_val("mid_rst_dest", completed_dest_reg, 0);
        check_val("mid_rst_ovf", overflow, 0);
        check_val("mid_rst_occ", occupancy, 0);
        check_val("mid_rst_halt", issue_halt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (completed_valid) n++;
        end
        check_val("no_stale", n, 0);
        run_one("post_rst", 5'd12, 8, 2, 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
